// File: rtl/fetch_receive_buffered_pkg.sv
// Shared constants and helpers for the buffered fetch receive stage.
// Holds the NOP encoding, a log2 helper and the FIFO entry width.
package fetch_receive_buffered_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  function automatic int fr_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int fr_entry_w(input int dw, input int aw);
    return dw + aw;
  endfunction

endpackage

// File: rtl/fetch_receive_buffered_fifo.sv
// DEPTH-entry synchronous FIFO holding {instruction, pc} pairs.
// Flush clears it in one cycle; push and pop may coincide at any occupancy.
module fetch_buffer_fifo
  import fetch_receive_buffered_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata,
  output logic [fr_clog2(DEPTH):0]  count,
  output logic                      full,
  output logic                      empty
);

  localparam int PTR_W = fr_clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = wdata;
        wr_d        = wr_q + PTR_W'(1);
      end
      if (pop) rd_d = rd_q + PTR_W'(1);
      unique case (1'b1)
        push && !pop: cnt_d = cnt_q + CNT_W'(1);
        pop && !push: cnt_d = cnt_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage needs no reset; count gates every read.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/fetch_receive_buffered.sv
// Buffered fetch receive stage: credit tracking, post-flush response
// dropping and a FIFO between instruction memory and decode.
module fetch_receive_buffered
  import fetch_receive_buffered_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    ADDRESS_BITS    = 32,
  parameter int                    DEPTH           = 4,
  parameter logic [DATA_WIDTH-1:0] NOP             = DATA_WIDTH'(RV_NOP),
  parameter int                    SCAN_CYCLES_MIN = 0,
  parameter int                    SCAN_CYCLES_MAX = 1000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    stall,
  input  logic                    fetch_issue,
  input  logic                    i_mem_valid,
  input  logic [DATA_WIDTH-1:0]   i_mem_data,
  input  logic [ADDRESS_BITS-1:0] i_mem_address,
  output logic [DATA_WIDTH-1:0]   instruction,
  output logic [ADDRESS_BITS-1:0] inst_PC,
  output logic                    valid,
  output logic                    buffer_full,
  output logic                    overflow,
  input  logic                    scan
);

  localparam int PTR_W = fr_clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = fr_entry_w(DATA_WIDTH, ADDRESS_BITS);

  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             ovf_q, ovf_d;
  int               cycle_q, cycle_d;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ENT_W-1:0] head;
  logic             accept;
  logic             push;
  logic             pop;
  logic [CNT_W:0]   credit_sum;

  assign valid  = !fifo_empty && !flush;
  assign pop    = valid && !stall;
  assign accept = i_mem_valid && !flush && (drop_q == '0);
  assign push   = accept && (!fifo_full || pop);

  fetch_buffer_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({i_mem_data, i_mem_address}),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    out_d   = out_q;
    drop_d  = drop_q;
    ovf_d   = ovf_q;
    cycle_d = cycle_q + 1;
    unique case (1'b1)
      fetch_issue && !i_mem_valid: out_d = out_q + CNT_W'(1);
      !fetch_issue && i_mem_valid: begin
        if (out_q == '0) ovf_d = 1'b1;
        else out_d = out_q - CNT_W'(1);
      end
      default: ;
    endcase
    // Responses still owed to the killed path must be swallowed.
    if (flush) begin
      if (!i_mem_valid) drop_d = out_q;
      else if (out_q != '0) drop_d = out_q - CNT_W'(1);
      else drop_d = '0;
    end else if (i_mem_valid && drop_q != '0) begin
      drop_d = drop_q - CNT_W'(1);
    end
    if (accept && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q   <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
      cycle_q <= 0;
    end else begin
      out_q   <= out_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      cycle_q <= cycle_d;
    end
  end

  assign credit_sum  = {1'b0, fifo_count} + {1'b0, out_q};
  assign buffer_full = credit_sum >= (CNT_W+1)'(DEPTH);
  assign overflow    = ovf_q;
  assign instruction = valid ? head[ENT_W-1:ADDRESS_BITS] : NOP;
  assign inst_PC     = valid ? head[ADDRESS_BITS-1:0] : '0;

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (!reset && scan &&
        cycle_q >= SCAN_CYCLES_MIN && cycle_q <= SCAN_CYCLES_MAX)
      $display("scan cyc=%0d count=%0d out=%0d drop=%0d inst=%h pc=%h",
               cycle_q, fifo_count, out_q, drop_q,
               head[ENT_W-1:ADDRESS_BITS], head[ADDRESS_BITS-1:0]);
  end
`endif

endmodule
